mmio_bridge: RTL and testbench
==============================

# mmio_bridge

Write-sequencing bridge between the hart's memory-mapped I/O port and up to NUM_TARGETS peripherals. It decodes each hart MMIO write to one target window and drives a req/ack handshake to that target. It returns a single write_complete pulse to the hart, which stalls until then. It also muxes peripheral read data back onto the hart's MMIO read bus and records decode, alignment and timeout errors in sticky status registers.

## Interface
- NUM_TARGETS, 4: number of peripheral windows (1..8)
- BASE_ADDR, 32'h8000_0000: start of the MMIO region
- SPAN_LOG2, 8: log2 of bytes per target window
- TIMEOUT_CYCLES, 64: maximum cycles to wait for tgt_ack (≥2)

- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- hart_control  in  mem_write_control_t  hart write request: addr, value, width, enable
- hart_write_complete  out  1  one-cycle pulse when the current write has finished or been dropped
- hart_r_data  out  XLEN  read data for hart_control.addr
- tgt_req  out  NUM_TARGETS  one-hot write request to a target
- tgt_addr  out  XLEN  byte offset within the window, zero-extended from addr[SPAN_LOG2-1:0]
- tgt_value  out  XLEN  write data
- tgt_width  out  mem_width_t  access width
- tgt_ack  in  NUM_TARGETS  target accepted the write
- tgt_r_data  in  NUM_TARGETS×XLEN  per-target read data (combinational in offset)
- error_clear  in  1  clears the sticky error state
- error_valid  out  1  sticky error flag
- error_addr  out  XLEN  address of the first error since the last clear

## Operation
- **Decode.**
  - An address is mapped iff BASE_ADDR ≤ addr < BASE_ADDR + (NUM_TARGETS << SPAN_LOG2).
  - Target index = (addr − BASE_ADDR) >> SPAN_LOG2.
  - Misaligned = word access with addr[1:0]≠0, or half access with addr[0]≠0.
- **FSM states:** IDLE, REQ, COMPLETE.
- **IDLE:**
  - enable & mapped & aligned → latch addr offset, value, width and index; go to REQ.
  - enable & (unmapped | misaligned) → record error; go to COMPLETE. The write is dropped and no tgt_req is raised.
- **REQ:**
  - tgt_req[idx]=1 with stable tgt_addr, tgt_value and tgt_width.
  - The timeout counter increments each cycle.
  - tgt_ack[idx]=1 → COMPLETE.
  - The counter reaches TIMEOUT_CYCLES−1 without ack → record error; go to COMPLETE.
  - tgt_ack on a non-selected index is ignored.
- **COMPLETE:** hart_write_complete=1 for exactly this cycle; go to IDLE.
- **Record error:** only if error_valid=0, set error_valid=1 and error_addr = full hart address (first error wins). If error_valid is already 1, error_addr is unchanged.
- **error_clear:** clears error_valid on the next edge. If error_clear and a new error occur in the same cycle, the new error wins: error_valid=1 and error_addr = the new address.
- **Read path:** hart_r_data = tgt_r_data[decode(hart_control.addr)] combinationally. It is 0 when the address is unmapped. It is independent of the FSM.

## Timing
- **Reset values:** state IDLE; tgt_req=0; hart_write_complete=0; error_valid=0; error_addr=0; tgt_addr, tgt_value, tgt_width, counter = 0.
- **Reset mid-REQ:** tgt_req drops asynchronously, the transaction is abandoned, and no complete is issued.
- **Hart handshake:**
  - The hart holds hart_control stable with enable=1 until it samples hart_write_complete=1.
  - A new request, including back-to-back, may be presented from the following cycle. The bridge samples it in IDLE.
- **Latency (enable first seen in cycle 0):**
  - tgt_req is high from cycle 1.
  - Ack in cycle k≥1 → hart_write_complete in cycle k+1.
  - The minimum is 2 cycles. The error path gives complete in cycle 1.
- **Target handshake:**
  - tgt_req holds until an ack edge; a one-cycle ack suffices.
  - tgt_req falls in the COMPLETE cycle.
- **Timeout:** tgt_req is high for exactly TIMEOUT_CYCLES cycles, then COMPLETE.

## Structure
- **Shared package:**
  - Existing XLEN, mem_width_t and mem_write_control_t.
  - Add mmio_bridge_state_t (IDLE/REQ/COMPLETE) and MMIO_BASE_ADDR as the default constant.
- **Sub-module:** mmio_addr_decoder, purely combinational: addr, width → mapped, aligned, index, offset. It is instantiated twice: once for the write path and once for the read mux.

## Test plan
- Word write of 0xDEADBEEF to 0x8000_0104, target 1 acks in the first REQ cycle → tgt_req=4'b0010 in cycle 1, tgt_addr=0x04, tgt_value=0xDEADBEEF, hart_write_complete in cycle 2 only, error_valid=0.
- Half write to 0x8000_0202, target 2 acks 5 cycles after req rises → tgt_req[2] high 6 cycles with stable fields, complete one cycle after ack, then a back-to-back word write to target 0 is issued the cycle after complete.
- Write to unmapped 0x8000_0400, then misaligned word write to 0x8000_0001 → no tgt_req, complete in cycle 1 each, error_valid=1, error_addr=0x8000_0400 (first error kept).
- Target 3 never acks, TIMEOUT_CYCLES=64 → tgt_req[3] high exactly 64 cycles, then complete, error_valid=1, error_addr=0x8000_0300+offset; error_clear → error_valid=0; error_clear coincident with a new error → error_valid stays 1 with the new address.
- reset_n low mid-REQ (cycle 3 of a target 2 wait) → tgt_req=0 immediately, all outputs at reset values, no complete; after release a new write completes normally.
- Read: hart_control.addr=0x8000_0108 with tgt_r_data[1]=0x1234_5678 → hart_r_data=0x1234_5678; addr 0x9000_0000 → hart_r_data=0.

Source files
------------

// File: rtl/mmio_bridge_pkg.sv
// Shared types for the MMIO write-sequencing bridge: hart write request,
// access width, bridge FSM states and the default MMIO region base.
package mmio_bridge_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] MMIO_BASE_ADDR = 32'h8000_0000;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_width_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] value;
    mem_width_t      width;
    logic            enable;
  } mem_write_control_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    COMPLETE = 2'd2
  } mmio_bridge_state_t;

  // Index/counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mmio_addr_decoder.sv
// Combinational decode of a hart address into target window index, byte
// offset within the window, and mapped/aligned qualifiers.
module mmio_addr_decoder
  import mmio_bridge_pkg::*;
#(
  parameter int              NUM_TARGETS = 4,
  parameter logic [XLEN-1:0] BASE_ADDR   = MMIO_BASE_ADDR,
  parameter int              SPAN_LOG2   = 8,
  localparam int             IDX_W       = clog2_min1(NUM_TARGETS)
) (
  input  logic [XLEN-1:0]  addr,
  input  mem_width_t       width,
  output logic             mapped,
  output logic             aligned,
  output logic [IDX_W-1:0] index,
  output logic [XLEN-1:0]  offset
);

  // One extra bit so a region ending exactly at 2^XLEN cannot wrap.
  localparam logic [XLEN:0]   REGION_BYTES = (XLEN+1)'(NUM_TARGETS) << SPAN_LOG2;
  localparam logic [XLEN-1:0] OFFSET_MASK  = XLEN'((64'd1 << SPAN_LOG2) - 64'd1);

  logic [XLEN-1:0] rel;

  assign rel    = addr - BASE_ADDR;
  assign mapped = (addr >= BASE_ADDR) && ({1'b0, rel} < REGION_BYTES);
  assign index  = IDX_W'(rel >> SPAN_LOG2);
  assign offset = addr & OFFSET_MASK;

  always_comb begin
    unique case (width)
      MEM_WORD: aligned = (addr[1:0] == 2'b00);
      MEM_HALF: aligned = !addr[0];
      default:  aligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/mmio_bridge.sv
// Sequences hart MMIO writes onto a per-target req/ack handshake, returns a
// single completion pulse, muxes read data and keeps sticky error status.
module mmio_bridge
  import mmio_bridge_pkg::*;
#(
  parameter int              NUM_TARGETS    = 4,
  parameter logic [XLEN-1:0] BASE_ADDR      = MMIO_BASE_ADDR,
  parameter int              SPAN_LOG2      = 8,
  parameter int              TIMEOUT_CYCLES = 64
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  mem_write_control_t                hart_control,
  output logic                              hart_write_complete,
  output logic [XLEN-1:0]                   hart_r_data,
  output logic [NUM_TARGETS-1:0]            tgt_req,
  output logic [XLEN-1:0]                   tgt_addr,
  output logic [XLEN-1:0]                   tgt_value,
  output mem_width_t                        tgt_width,
  input  logic [NUM_TARGETS-1:0]            tgt_ack,
  input  logic [NUM_TARGETS-1:0][XLEN-1:0]  tgt_r_data,
  input  logic                              error_clear,
  output logic                              error_valid,
  output logic [XLEN-1:0]                   error_addr
);

  localparam int IDX_W = clog2_min1(NUM_TARGETS);
  localparam int CNT_W = clog2_min1(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mmio_bridge_state_t state, state_next;

  logic             wr_mapped, wr_aligned;
  logic [IDX_W-1:0] wr_idx;
  logic [XLEN-1:0]  wr_offset;

  logic             rd_mapped, rd_aligned;
  logic [IDX_W-1:0] rd_idx;
  logic [XLEN-1:0]  rd_offset;

  logic [IDX_W-1:0] req_idx;
  logic [XLEN-1:0]  req_addr;
  logic [CNT_W-1:0] cnt;

  logic             accept, reject, timeout, ack_sel;
  logic             err_event;
  logic [XLEN-1:0]  err_addr_new;

  mmio_addr_decoder #(
    .NUM_TARGETS (NUM_TARGETS),
    .BASE_ADDR   (BASE_ADDR),
    .SPAN_LOG2   (SPAN_LOG2)
  ) u_wr_decode (
    .addr    (hart_control.addr),
    .width   (hart_control.width),
    .mapped  (wr_mapped),
    .aligned (wr_aligned),
    .index   (wr_idx),
    .offset  (wr_offset)
  );

  // Reads ignore width, so the read decoder's alignment and offset go unused.
  mmio_addr_decoder #(
    .NUM_TARGETS (NUM_TARGETS),
    .BASE_ADDR   (BASE_ADDR),
    .SPAN_LOG2   (SPAN_LOG2)
  ) u_rd_decode (
    .addr    (hart_control.addr),
    .width   (MEM_BYTE),
    .mapped  (rd_mapped),
    .aligned (rd_aligned),
    .index   (rd_idx),
    .offset  (rd_offset)
  );

  logic unused_rd;
  assign unused_rd = &{1'b0, rd_aligned, rd_offset};

  assign hart_r_data = rd_mapped ? tgt_r_data[rd_idx] : '0;

  assign ack_sel = tgt_ack[req_idx];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // tgt_req and the completion pulse are decoded from the state register, so
  // an asynchronous reset drops them immediately.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    state_next          = state;
    accept              = 1'b0;
    reject              = 1'b0;
    timeout             = 1'b0;
    hart_write_complete = 1'b0;
    tgt_req             = '0;
    unique case (state)
      IDLE: begin
        if (hart_control.enable) begin
          if (wr_mapped && wr_aligned) begin
            accept     = 1'b1;
            state_next = REQ;
          end else begin
            reject     = 1'b1;
            state_next = COMPLETE;
          end
        end
      end
      REQ: begin
        tgt_req = NUM_TARGETS'(1'b1) << req_idx;
        if (ack_sel) begin
          state_next = COMPLETE;
        end else if (cnt == CNT_LAST) begin
          timeout    = 1'b1;
          state_next = COMPLETE;
        end
      end
      COMPLETE: begin
        hart_write_complete = 1'b1;
        state_next          = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Transaction fields are frozen at accept so the target sees stable values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tgt_addr  <= '0;
      tgt_value <= '0;
      tgt_width <= MEM_BYTE;
      req_idx   <= '0;
      req_addr  <= '0;
      cnt       <= '0;
    end else if (accept) begin
      tgt_addr  <= wr_offset;
      tgt_value <= hart_control.value;
      tgt_width <= hart_control.width;
      req_idx   <= wr_idx;
      req_addr  <= hart_control.addr;
      cnt       <= '0;
    end else if (state == REQ) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign err_event    = reject | timeout;
  assign err_addr_new = reject ? hart_control.addr : req_addr;

  // First error wins, except that a clear in the same cycle lets the new one in.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      error_valid <= 1'b0;
      error_addr  <= '0;
    end else if (err_event && (!error_valid || error_clear)) begin
      error_valid <= 1'b1;
      error_addr  <= err_addr_new;
    end else if (error_clear) begin
      error_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmio_bridge.sv
// Scoreboard bench for mmio_bridge: the driver queues expected completions,
// a negedge monitor pops and checks them against observed target activity.
module tb_mmio_bridge;
  import mmio_bridge_pkg::*;

  localparam int NT = 4;

  logic                       clock = 1'b0;
  logic                       reset_n = 1'b0;
  mem_write_control_t         hart_control;
  logic                       hart_write_complete;
  logic [XLEN-1:0]            hart_r_data;
  logic [NT-1:0]              tgt_req;
  logic [XLEN-1:0]            tgt_addr;
  logic [XLEN-1:0]            tgt_value;
  mem_width_t                 tgt_width;
  logic [NT-1:0]              tgt_ack;
  logic [NT-1:0][XLEN-1:0]    tgt_r_data;
  logic                       error_clear;
  logic                       error_valid;
  logic [XLEN-1:0]            error_addr;

  mmio_bridge #(
    .NUM_TARGETS    (NT),
    .BASE_ADDR      (32'h8000_0000),
    .SPAN_LOG2      (8),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .hart_control        (hart_control),
    .hart_write_complete (hart_write_complete),
    .hart_r_data         (hart_r_data),
    .tgt_req             (tgt_req),
    .tgt_addr            (tgt_addr),
    .tgt_value           (tgt_value),
    .tgt_width           (tgt_width),
    .tgt_ack             (tgt_ack),
    .tgt_r_data          (tgt_r_data),
    .error_clear         (error_clear),
    .error_valid         (error_valid),
    .error_addr          (error_addr)
  );

  always #5 clock = ~clock;

  typedef struct {
    string           name;
    int              issue;
    int              lat;
    logic [NT-1:0]   mask;
    int              nreq;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] value;
    mem_width_t      width;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Target model: each target acks after ack_delay[i] cycles of req (-1: never).
  int            ack_delay[NT];
  int            age[NT];
  logic [NT-1:0] ack_v;
  logic [NT-1:0] ack_noise;

  always @(posedge clock) begin
    #1;
    for (int i = 0; i < NT; i++) begin
      if (tgt_req[i]) begin
        ack_v[i] = (age[i] == ack_delay[i]);
        age[i]++;
      end else begin
        ack_v[i] = 1'b0;
        age[i]   = 0;
      end
    end
    tgt_ack = ack_v | ack_noise;
  end

  // Monitor: accumulate target activity, score it on each completion pulse.
  logic [NT-1:0]   seen_mask;
  int              seen_n;
  logic [XLEN-1:0] seen_addr, seen_value;
  mem_width_t      seen_width;
  bit              unstable;

  always @(negedge clock) begin
    if (!reset_n) begin
      seen_mask = '0;
      seen_n    = 0;
      unstable  = 1'b0;
    end else begin
      if (tgt_req != '0) begin
        if (seen_n == 0) begin
          seen_addr  = tgt_addr;
          seen_value = tgt_value;
          seen_width = tgt_width;
        end else if (tgt_addr !== seen_addr || tgt_value !== seen_value ||
                     tgt_width !== seen_width) begin
          unstable = 1'b1;
        end
        seen_mask |= tgt_req;
        seen_n++;
      end
      if (hart_write_complete) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_complete: complete seen at cycle %0d, required none", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check({mon_e.name, "_latency"}, 64'(cyc - mon_e.issue), 64'(mon_e.lat));
          check({mon_e.name, "_req_mask"}, 64'(seen_mask), 64'(mon_e.mask));
          check({mon_e.name, "_req_cycles"}, 64'(seen_n), 64'(mon_e.nreq));
          if (mon_e.nreq > 0) begin
            check({mon_e.name, "_tgt_addr"}, 64'(seen_addr), 64'(mon_e.addr));
            check({mon_e.name, "_tgt_value"}, 64'(seen_value), 64'(mon_e.value));
            check({mon_e.name, "_tgt_width"}, 64'(seen_width), 64'(mon_e.width));
            check({mon_e.name, "_stable"}, 64'(unstable), 64'(0));
          end
        end
        seen_mask = '0;
        seen_n    = 0;
        unstable  = 1'b0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after completion.
  task automatic do_write(input string name, input logic [XLEN-1:0] addr,
                          input logic [XLEN-1:0] value, input mem_width_t w,
                          input logic [NT-1:0] mask, input int nreq, input int lat,
                          input logic clr);
    exp_t e;
    bit   done;
    e.name  = name;
    e.issue = cyc;
    e.lat   = lat;
    e.mask  = mask;
    e.nreq  = nreq;
    e.addr  = addr & 32'h0000_00FF;
    e.value = value;
    e.width = w;
    exp_q.push_back(e);
    hart_control = '{addr: addr, value: value, width: w, enable: 1'b1};
    error_clear  = clr;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clock);
      #1;
      error_clear = 1'b0;
      if (hart_write_complete) done = 1'b1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s_wait: no complete within 200 cycles, required one", name);
    end
    @(posedge clock);
    #1;
    hart_control.enable = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required normal end");
    $fatal(1, "watchdog");
  end

  initial begin
    hart_control = '0;
    tgt_ack      = '0;
    ack_v        = '0;
    ack_noise    = '0;
    error_clear  = 1'b0;
    for (int i = 0; i < NT; i++) begin
      ack_delay[i] = -1;
      age[i]       = 0;
    end
    tgt_r_data[0] = 32'hA0A0_A0A0;
    tgt_r_data[1] = 32'h1234_5678;
    tgt_r_data[2] = 32'hB2B2_B2B2;
    tgt_r_data[3] = 32'hC3C3_C3C3;

    repeat (3) @(posedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("rst_tgt_req", 64'(tgt_req), 64'(0));
    check("rst_complete", 64'(hart_write_complete), 64'(0));
    check("rst_err_valid", 64'(error_valid), 64'(0));
    check("rst_err_addr", 64'(error_addr), 64'(0));
    check("rst_tgt_value", 64'(tgt_value), 64'(0));

    hart_control.addr = 32'h8000_0108; #1;
    check("rd_t1", 64'(hart_r_data), 64'h1234_5678);
    hart_control.addr = 32'h9000_0000; #1;
    check("rd_unmapped_high", 64'(hart_r_data), 64'(0));
    hart_control.addr = 32'h8000_03FF; #1;
    check("rd_top_edge", 64'(hart_r_data), 64'hC3C3_C3C3);
    hart_control.addr = 32'h8000_0400; #1;
    check("rd_past_end", 64'(hart_r_data), 64'(0));
    hart_control.addr = 32'h7FFF_FFFF; #1;
    check("rd_below_base", 64'(hart_r_data), 64'(0));
    hart_control.addr = 32'h8000_0000; #1;
    check("rd_base", 64'(hart_r_data), 64'hA0A0_A0A0);
    @(posedge clock);
    #1;

    ack_delay[1] = 0;
    do_write("t1_word", 32'h8000_0104, 32'hDEAD_BEEF, MEM_WORD, 4'b0010, 1, 2, 1'b0);
    check("t1_err_valid", 64'(error_valid), 64'(0));

    ack_delay[2] = 5;
    ack_delay[0] = 2;
    ack_noise    = 4'b1010;
    do_write("t2_half", 32'h8000_0202, 32'h0000_BEEF, MEM_HALF, 4'b0100, 6, 7, 1'b0);
    do_write("t0_b2b", 32'h8000_0008, 32'h1122_3344, MEM_WORD, 4'b0001, 3, 4, 1'b0);
    ack_noise    = '0;
    ack_delay[0] = 0;
    do_write("t0_byte", 32'h8000_0003, 32'h0000_00A5, MEM_BYTE, 4'b0001, 1, 2, 1'b0);
    check("ok_err_valid", 64'(error_valid), 64'(0));

    do_write("unmapped", 32'h8000_0400, 32'h0000_0001, MEM_WORD, 4'b0000, 0, 1, 1'b0);
    check("unmapped_err_valid", 64'(error_valid), 64'(1));
    check("unmapped_err_addr", 64'(error_addr), 64'h8000_0400);
    do_write("misal_word", 32'h8000_0001, 32'h0000_0002, MEM_WORD, 4'b0000, 0, 1, 1'b0);
    do_write("misal_half", 32'h8000_0203, 32'h0000_0003, MEM_HALF, 4'b0000, 0, 1, 1'b0);
    check("first_err_kept", 64'(error_addr), 64'h8000_0400);

    error_clear = 1'b1;
    @(posedge clock);
    #1;
    error_clear = 1'b0;
    check("clear_err_valid", 64'(error_valid), 64'(0));

    ack_delay[3] = -1;
    do_write("t3_timeout", 32'h8000_03FC, 32'hCAFE_F00D, MEM_WORD, 4'b1000, 64, 65, 1'b0);
    check("timeout_err_valid", 64'(error_valid), 64'(1));
    check("timeout_err_addr", 64'(error_addr), 64'h8000_03FC);

    do_write("clr_and_err", 32'h7FFF_FFFC, 32'h0, MEM_WORD, 4'b0000, 0, 1, 1'b1);
    check("clr_err_valid", 64'(error_valid), 64'(1));
    check("clr_err_addr", 64'(error_addr), 64'h7FFF_FFFC);

    ack_delay[2] = -1;
    hart_control = '{addr: 32'h8000_0200, value: 32'h0000_0077, width: MEM_WORD, enable: 1'b1};
    repeat (3) @(posedge clock);
    #3;
    check("mid_req_active", 64'(tgt_req), 64'(4'b0100));
    reset_n = 1'b0;
    #1;
    check("midrst_tgt_req", 64'(tgt_req), 64'(0));
    check("midrst_complete", 64'(hart_write_complete), 64'(0));
    check("midrst_err_valid", 64'(error_valid), 64'(0));
    check("midrst_err_addr", 64'(error_addr), 64'(0));
    check("midrst_tgt_value", 64'(tgt_value), 64'(0));
    check("midrst_tgt_width", 64'(tgt_width), 64'(MEM_BYTE));
    hart_control.enable = 1'b0;
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    @(posedge clock);
    #1;
    ack_delay[2] = 1;
    do_write("post_reset", 32'h8000_0204, 32'h55AA_55AA, MEM_WORD, 4'b0100, 2, 3, 1'b0);

    repeat (3) @(posedge clock);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
